// File: rtl/rv_mc_system_if.sv
// Unified memory bus between the multi-cycle core (master) and the
// single-port synchronous-read memory (slave).
interface rv_mc_system_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);
endinterface

// File: rtl/rv_mc_system.sv
// Multi-cycle RV32I-subset processor system: control FSM driven core plus a
// unified instruction/data memory with one-cycle synchronous read.

// Unified word memory; word index is the byte address >> 2, wrapping.
module rv_mc_mem #(
  parameter int MEM_WORDS = 256
) (
  input logic           clk,
  rv_mc_system_if.slave bus
);
  localparam int AW = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;

  logic [31:0]   M [0:MEM_WORDS-1];
  logic [31:0]   r_rdata;
  logic [AW-1:0] w_idx;

  assign w_idx     = AW'((bus.addr >> 2) % MEM_WORDS);
  assign bus.rdata = r_rdata;

  // Registered read every cycle; write when the core is in its store state
  always_ff @(posedge clk) begin
    if (bus.we) M[w_idx] <= bus.wdata;
    r_rdata <= M[w_idx];
  end
endmodule

// 32 x 32 register file: two asynchronous reads, one clocked write, x0 hardwired.
module rv_mc_regfile (
  input  logic        clk,
  input  logic        i_we,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);
  logic [31:0] RFMem [0:31];

  assign o_rd1 = (i_ra1 == 5'd0) ? 32'd0 : RFMem[i_ra1];
  assign o_rd2 = (i_ra2 == 5'd0) ? 32'd0 : RFMem[i_ra2];

  // Write-back port; writes aimed at x0 are dropped
  always_ff @(posedge clk) begin
    if (i_we && (i_wa != 5'd0)) RFMem[i_wa] <= i_wd;
  end
endmodule

// 32-bit ALU; ctrl is {funct7[5], funct3} with the alternate bit only
// meaningful for add/sub and srl/sra.
module rv_mc_alu (
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic [3:0]  i_ctrl,
  output logic [31:0] o_out
);
  logic [31:0]        out;
  logic signed [31:0] w_a_s;
  logic signed [31:0] w_b_s;
  logic [31:0]        w_sra;

  assign w_a_s = i_a;
  assign w_b_s = i_b;
  assign w_sra = w_a_s >>> i_b[4:0];
  assign o_out = out;

  // Operation select
  always_comb begin
    out = 32'd0;
    case (i_ctrl[2:0])
      3'b000:  out = i_ctrl[3] ? (i_a - i_b) : (i_a + i_b);
      3'b001:  out = i_a << i_b[4:0];
      3'b010:  out = {31'd0, (w_a_s < w_b_s)};
      3'b011:  out = {31'd0, (i_a < i_b)};
      3'b100:  out = i_a ^ i_b;
      3'b101:  out = i_ctrl[3] ? w_sra : (i_a >> i_b[4:0]);
      3'b110:  out = i_a | i_b;
      default: out = i_a & i_b;
    endcase
  end
endmodule

// Instruction field extraction and immediate sign extension by format.
module rv_mc_decode (
  input  logic [31:0] i_ir,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic [2:0]  o_f3,
  output logic        o_f7b5,
  output logic [31:0] o_imm
);
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic signed [31:0] imm_ext;

  assign rs1    = i_ir[19:15];
  assign rs2    = i_ir[24:20];
  assign o_rs1  = rs1;
  assign o_rs2  = rs2;
  assign o_rd   = i_ir[11:7];
  assign o_f3   = i_ir[14:12];
  assign o_f7b5 = i_ir[30];
  assign o_imm  = imm_ext;

  // Immediate format chosen by opcode; I-format is the fallback
  always_comb begin
    imm_ext = {{20{i_ir[31]}}, i_ir[31:20]};
    case (i_ir[6:0])
      7'b0100011: imm_ext = {{20{i_ir[31]}}, i_ir[31:25], i_ir[11:7]};
      7'b1100011: imm_ext = {{20{i_ir[31]}}, i_ir[7], i_ir[30:25], i_ir[11:8], 1'b0};
      7'b1101111: imm_ext = {{12{i_ir[31]}}, i_ir[19:12], i_ir[20], i_ir[30:21], 1'b0};
      7'b0110111: imm_ext = {i_ir[31:12], 12'd0};
      default:    imm_ext = {{20{i_ir[31]}}, i_ir[31:20]};
    endcase
  end
endmodule

// Program counter: advances by 4 on the fetch edge (saving old_pc), or loads
// a branch/jump target.
module rv_mc_fetch #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_pc_inc,
  input  logic        i_pc_ld,
  input  logic [31:0] i_pc_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_old_pc
);
  logic [31:0] pc_cur;
  logic [31:0] r_old_pc;

  assign o_pc     = pc_cur;
  assign o_old_pc = r_old_pc;

  // PC update
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_cur   <= RESET_PC;
      r_old_pc <= RESET_PC;
    end else if (i_pc_inc) begin
      r_old_pc <= pc_cur;
      pc_cur   <= pc_cur + 32'd4;
    end else if (i_pc_ld) begin
      pc_cur <= i_pc_target;
    end
  end
endmodule

// Control FSM: one instruction at a time, Moore-style control outputs.
module rv_mc_control_fsm (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] i_opcode,
  output logic       o_pc_inc,
  output logic       o_ir_we,
  output logic       o_adr_data,
  output logic       o_mem_we,
  output logic       o_rf_we,
  output logic       o_wb_mem,
  output logic       o_wb_pc,
  output logic       o_wb_imm,
  output logic       o_alu_r,
  output logic       o_alu_i,
  output logic       o_alu_pc,
  output logic       o_aluout_we,
  output logic       o_branch,
  output logic       o_jal
);
  localparam logic [5:0] FETCH      = 6'd0;
  localparam logic [5:0] FETCH_WAIT = 6'd1;
  localparam logic [5:0] DECODE     = 6'd2;
  localparam logic [5:0] MEMADR     = 6'd3;
  localparam logic [5:0] MEMREAD    = 6'd4;
  localparam logic [5:0] MEMWB      = 6'd5;
  localparam logic [5:0] MEMWRITE   = 6'd6;
  localparam logic [5:0] EXECUTER   = 6'd7;
  localparam logic [5:0] EXECUTEI   = 6'd8;
  localparam logic [5:0] ALUWB      = 6'd9;
  localparam logic [5:0] BRANCH     = 6'd10;
  localparam logic [5:0] JAL        = 6'd11;
  localparam logic [5:0] LUI        = 6'd12;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  logic [5:0] current_state;
  logic [5:0] w_next_state;

  // State register; reset aborts any instruction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) current_state <= FETCH;
    else       current_state <= w_next_state;
  end

  // Next-state sequencing
  always_comb begin
    w_next_state = FETCH;
    case (current_state)
      FETCH:      w_next_state = FETCH_WAIT;
      FETCH_WAIT: w_next_state = DECODE;
      DECODE: begin
        case (i_opcode)
          OP_LOAD, OP_STORE: w_next_state = MEMADR;
          OP_R:              w_next_state = EXECUTER;
          OP_I:              w_next_state = EXECUTEI;
          OP_BR:             w_next_state = BRANCH;
          OP_JAL:            w_next_state = JAL;
          OP_LUI:            w_next_state = LUI;
          default:           w_next_state = FETCH;
        endcase
      end
      MEMADR:     w_next_state = (i_opcode == OP_LOAD) ? MEMREAD : MEMWRITE;
      MEMREAD:    w_next_state = MEMWB;
      EXECUTER:   w_next_state = ALUWB;
      EXECUTEI:   w_next_state = ALUWB;
      default:    w_next_state = FETCH;
    endcase
  end

  // Control outputs decoded from the current state
  always_comb begin
    o_pc_inc    = 1'b0;
    o_ir_we     = 1'b0;
    o_adr_data  = 1'b1;
    o_mem_we    = 1'b0;
    o_rf_we     = 1'b0;
    o_wb_mem    = 1'b0;
    o_wb_pc     = 1'b0;
    o_wb_imm    = 1'b0;
    o_alu_r     = 1'b0;
    o_alu_i     = 1'b0;
    o_alu_pc    = 1'b0;
    o_aluout_we = 1'b0;
    o_branch    = 1'b0;
    o_jal       = 1'b0;
    case (current_state)
      FETCH:      begin o_adr_data = 1'b0; o_pc_inc = 1'b1; end
      FETCH_WAIT: o_ir_we = 1'b1;
      MEMADR:     o_aluout_we = 1'b1;
      MEMWB:      begin o_rf_we = 1'b1; o_wb_mem = 1'b1; end
      MEMWRITE:   o_mem_we = 1'b1;
      EXECUTER:   begin o_alu_r = 1'b1; o_aluout_we = 1'b1; end
      EXECUTEI:   begin o_alu_i = 1'b1; o_aluout_we = 1'b1; end
      ALUWB:      o_rf_we = 1'b1;
      BRANCH:     begin o_alu_pc = 1'b1; o_branch = 1'b1; end
      JAL:        begin o_alu_pc = 1'b1; o_jal = 1'b1; o_rf_we = 1'b1; o_wb_pc = 1'b1; end
      LUI:        begin o_rf_we = 1'b1; o_wb_imm = 1'b1; end
      default:    ;
    endcase
  end
endmodule

// Core datapath: IR, ALU-result register, operand muxes and write-back.
module rv_mc_core #(
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input logic            clk,
  input logic            reset,
  rv_mc_system_if.master bus
);
  logic [31:0] r_ir;
  logic [31:0] r_aluout;
  logic [6:0]  opcode;
  logic [31:0] memory__address;

  logic [4:0]  w_rs1, w_rs2, w_rd;
  logic [2:0]  w_f3;
  logic        w_f7b5;
  logic [31:0] w_imm, w_rs1_val, w_rs2_val, w_rf_wd;
  logic [31:0] w_pc, w_old_pc, w_alu_a, w_alu_b, w_alu_out;
  logic [3:0]  w_alu_ctrl;
  logic        w_pc_inc, w_ir_we, w_adr_data, w_mem_we, w_rf_we;
  logic        w_wb_mem, w_wb_pc, w_wb_imm, w_alu_r, w_alu_i, w_alu_pc;
  logic        w_aluout_we, w_branch, w_jal, w_take;

  assign opcode          = r_ir[6:0];
  assign memory__address = w_adr_data ? r_aluout : w_pc;
  assign bus.addr        = memory__address;
  assign bus.wdata       = w_rs2_val;
  assign bus.we          = w_mem_we;

  // Only beq/bne are supported; any other branch funct3 falls through
  assign w_take = w_branch &&
                  (((w_f3 == 3'b000) && (w_rs1_val == w_rs2_val)) ||
                   ((w_f3 == 3'b001) && (w_rs1_val != w_rs2_val)));

  rv_mc_control_fsm control_fsm (
    .clk(clk), .reset(reset), .i_opcode(opcode),
    .o_pc_inc(w_pc_inc), .o_ir_we(w_ir_we), .o_adr_data(w_adr_data),
    .o_mem_we(w_mem_we), .o_rf_we(w_rf_we), .o_wb_mem(w_wb_mem),
    .o_wb_pc(w_wb_pc), .o_wb_imm(w_wb_imm), .o_alu_r(w_alu_r),
    .o_alu_i(w_alu_i), .o_alu_pc(w_alu_pc), .o_aluout_we(w_aluout_we),
    .o_branch(w_branch), .o_jal(w_jal)
  );

  rv_mc_fetch #(.RESET_PC(RESET_PC)) fetch (
    .clk(clk), .reset(reset), .i_pc_inc(w_pc_inc), .i_pc_ld(w_jal | w_take),
    .i_pc_target(w_alu_out), .o_pc(w_pc), .o_old_pc(w_old_pc)
  );

  rv_mc_decode instruction_decode (
    .i_ir(r_ir), .o_rs1(w_rs1), .o_rs2(w_rs2), .o_rd(w_rd),
    .o_f3(w_f3), .o_f7b5(w_f7b5), .o_imm(w_imm)
  );

  rv_mc_regfile RegFile (
    .clk(clk), .i_we(w_rf_we), .i_ra1(w_rs1), .i_ra2(w_rs2), .i_wa(w_rd),
    .i_wd(w_rf_wd), .o_rd1(w_rs1_val), .o_rd2(w_rs2_val)
  );

  rv_mc_alu alu (
    .i_a(w_alu_a), .i_b(w_alu_b), .i_ctrl(w_alu_ctrl), .o_out(w_alu_out)
  );

  // ALU operands: rs1+imm by default (address calc), PC-relative for control flow
  always_comb begin
    w_alu_a    = w_rs1_val;
    w_alu_b    = w_imm;
    w_alu_ctrl = 4'b0000;
    if (w_alu_r) begin
      w_alu_b    = w_rs2_val;
      w_alu_ctrl = {w_f7b5, w_f3};
    end else if (w_alu_i) begin
      w_alu_ctrl = {(w_f3 == 3'b101) & w_f7b5, w_f3};
    end else if (w_alu_pc) begin
      w_alu_a = w_old_pc;
    end
  end

  // Register write-back source
  always_comb begin
    w_rf_wd = r_aluout;
    if (w_wb_mem)      w_rf_wd = bus.rdata;
    else if (w_wb_pc)  w_rf_wd = w_pc;
    else if (w_wb_imm) w_rf_wd = w_imm;
  end

  // Instruction register and ALU-result register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ir     <= 32'd0;
      r_aluout <= 32'd0;
    end else begin
      if (w_ir_we)     r_ir     <= bus.rdata;
      if (w_aluout_we) r_aluout <= w_alu_out;
    end
  end
endmodule

// System top: core plus unified memory.
module rv_mc_system #(
  parameter int          MEM_WORDS = 256,
  parameter logic [31:0] RESET_PC  = 32'd0
) (
  input logic clk,
  input logic reset
);
  rv_mc_system_if w_bus ();

  rv_mc_core #(.RESET_PC(RESET_PC)) core (
    .clk(clk), .reset(reset), .bus(w_bus.master)
  );

  rv_mc_mem #(.MEM_WORDS(MEM_WORDS)) memory (
    .clk(clk), .bus(w_bus.slave)
  );
endmodule

// File: tb/tb_rv_mc_system.sv
// Bench for rv_mc_system: directed ISA scenarios plus randomized ALU programs
// checked against an instruction-level reference model.
module tb_rv_mc_system;
  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  rv_mc_system #(.MEM_WORDS(256), .RESET_PC(32'd0)) dut (.clk(clk), .reset(reset));

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3, input logic [4:0] rd);
    return {f7, rs2, rs1, f3, rd, 7'b0110011};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd, input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction
  function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2, input logic [4:0] rs1);
    return {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [4:0] rs2,
                                        input logic [4:0] rs1, input logic [2:0] f3);
    return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] enc_j(input logic [20:0] imm, input logic [4:0] rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
  endfunction

  // ISA-level result of an integer op (sub/sra selected by alt)
  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                          input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sa, sb, sr;
    sa = a; sb = b; sr = sa >>> b[4:0];
    case (f3)
      3'd0: return alt ? a - b : a + b;
      3'd1: return a << b[4:0];
      3'd2: return (sa < sb) ? 32'd1 : 32'd0;
      3'd3: return (a < b) ? 32'd1 : 32'd0;
      3'd4: return a ^ b;
      3'd5: return alt ? sr : a >> b[4:0];
      3'd6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk); @(negedge clk);
  endtask

  task automatic hold_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 64; i++) dut.memory.M[i] = 32'd0;
    for (int i = 0; i < 32; i++) dut.core.RegFile.RFMem[i] = 32'd0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_fetch_at(input logic [31:0] end_pc, input int budget, output bit ok);
    ok = 1'b0;
    for (int c = 0; c < budget; c++) begin
      if (dut.core.control_fsm.current_state == 6'd0 && dut.core.fetch.pc_cur == end_pc) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    hold_reset();
    n_cmp++; if (dut.core.control_fsm.current_state !== 6'd0) begin n_bad++; $display("FAIL reset_state: got %0d want 0", dut.core.control_fsm.current_state); end
    n_cmp++; if (dut.core.fetch.pc_cur !== 32'd0) begin n_bad++; $display("FAIL reset_pc: got %h want 0", dut.core.fetch.pc_cur); end
    n_cmp++; if (dut.core.opcode !== 7'd0) begin n_bad++; $display("FAIL reset_ir: got %b want 0", dut.core.opcode); end
  endtask

  task automatic test_sw_sequence();
    hold_reset();
    dut.core.RegFile.RFMem[6] = 32'd44;
    dut.core.RegFile.RFMem[5] = 32'd256;
    dut.memory.M[0] = 32'h00532023;
    dut.memory.M[1] = 32'h00532223;
    dut.memory.M[2] = 32'h00532423;
    release_reset();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (dut.core.control_fsm.current_state !== 6'd1) begin n_bad++; $display("FAIL sw%0d_fetch_wait: got %0d want 1", k, dut.core.control_fsm.current_state); end
      tick();
      n_cmp++; if (dut.core.control_fsm.current_state !== 6'd2 || dut.core.opcode !== 7'b0100011) begin n_bad++; $display("FAIL sw%0d_decode: state %0d opcode %b want 2/0100011", k, dut.core.control_fsm.current_state, dut.core.opcode); end
      n_cmp++; if (dut.core.instruction_decode.rs1 !== 5'd6 || dut.core.instruction_decode.rs2 !== 5'd5 || dut.core.instruction_decode.imm_ext !== 32'(4*k)) begin n_bad++; $display("FAIL sw%0d_fields: rs1 %0d rs2 %0d imm %h want 6/5/%0d", k, dut.core.instruction_decode.rs1, dut.core.instruction_decode.rs2, dut.core.instruction_decode.imm_ext, 4*k); end
      tick();
      n_cmp++; if (dut.core.control_fsm.current_state !== 6'd3 || dut.core.alu.out !== 32'(44 + 4*k)) begin n_bad++; $display("FAIL sw%0d_memadr: state %0d alu %0d want 3/%0d", k, dut.core.control_fsm.current_state, dut.core.alu.out, 44 + 4*k); end
      tick();
      n_cmp++; if (dut.core.control_fsm.current_state !== 6'd6 || dut.core.memory__address !== 32'(44 + 4*k)) begin n_bad++; $display("FAIL sw%0d_memwrite: state %0d addr %0d want 6/%0d", k, dut.core.control_fsm.current_state, dut.core.memory__address, 44 + 4*k); end
      tick();
      n_cmp++; if (dut.memory.M[11 + k] !== 32'd256 || dut.core.fetch.pc_cur !== 32'(4*k + 4) || dut.core.control_fsm.current_state !== 6'd0) begin n_bad++; $display("FAIL sw%0d_done: M %h pc %0d state %0d want 100/%0d/0", k, dut.memory.M[11 + k], dut.core.fetch.pc_cur, dut.core.control_fsm.current_state, 4*k + 4); end
    end
    n_cmp++; if (dut.core.RegFile.RFMem[5] !== 32'd256 || dut.core.RegFile.RFMem[6] !== 32'd44) begin n_bad++; $display("FAIL sw_regs_kept: x5 %0d x6 %0d want 256/44", dut.core.RegFile.RFMem[5], dut.core.RegFile.RFMem[6]); end
  endtask

  task automatic test_lw();
    logic [5:0] exp_st [0:4];
    exp_st = '{6'd1, 6'd2, 6'd3, 6'd4, 6'd5};
    hold_reset();
    dut.core.RegFile.RFMem[6] = 32'd44;
    dut.memory.M[12] = 32'hCAFEBABE;
    dut.memory.M[0] = enc_i(12'd4, 5'd6, 3'b010, 5'd7, 7'b0000011);
    release_reset();
    for (int s = 0; s < 5; s++) begin
      tick();
      n_cmp++; if (dut.core.control_fsm.current_state !== exp_st[s]) begin n_bad++; $display("FAIL lw_state%0d: got %0d want %0d", s, dut.core.control_fsm.current_state, exp_st[s]); end
    end
    tick();
    n_cmp++; if (dut.core.RegFile.RFMem[7] !== 32'hCAFEBABE) begin n_bad++; $display("FAIL lw_result: got %h want cafebabe", dut.core.RegFile.RFMem[7]); end
  endtask

  task automatic test_alu_directed();
    bit ok;
    hold_reset();
    dut.memory.M[0] = enc_i(12'hFFF, 5'd0, 3'b000, 5'd1, 7'b0010011);
    dut.memory.M[1] = enc_r(7'd0, 5'd1, 5'd1, 3'b000, 5'd2);
    dut.memory.M[2] = enc_r(7'd0, 5'd1, 5'd0, 3'b011, 5'd3);
    dut.memory.M[3] = enc_i(12'd5, 5'd1, 3'b000, 5'd0, 7'b0010011);
    dut.memory.M[4] = enc_r(7'd0, 5'd1, 5'd1, 3'b000, 5'd0);
    release_reset();
    wait_fetch_at(32'd20, 200, ok);
    n_cmp++; if (!ok) begin n_bad++; $display("FAIL alu_dir_timeout: pc %h want 14", dut.core.fetch.pc_cur); end
    n_cmp++; if (dut.core.RegFile.RFMem[1] !== 32'hFFFFFFFF) begin n_bad++; $display("FAIL addi_neg: got %h want ffffffff", dut.core.RegFile.RFMem[1]); end
    n_cmp++; if (dut.core.RegFile.RFMem[2] !== 32'hFFFFFFFE) begin n_bad++; $display("FAIL add_wrap: got %h want fffffffe", dut.core.RegFile.RFMem[2]); end
    n_cmp++; if (dut.core.RegFile.RFMem[3] !== 32'd1) begin n_bad++; $display("FAIL sltu: got %h want 1", dut.core.RegFile.RFMem[3]); end
    n_cmp++; if (dut.core.RegFile.RFMem[0] !== 32'd0) begin n_bad++; $display("FAIL x0_write: got %h want 0", dut.core.RegFile.RFMem[0]); end
  endtask

  task automatic test_alu_random();
    logic [31:0] mreg [0:7];
    logic [31:0] instr, a, b, res;
    logic [4:0]  rd, rs1, rs2;
    logic [2:0]  f3;
    logic [11:0] imm;
    logic [19:0] uimm;
    logic        alt;
    int          kind;
    bit          ok;
    for (int r = 0; r < 4; r++) begin
      hold_reset();
      mreg[0] = 32'd0;
      for (int i = 1; i < 8; i++) begin
        mreg[i] = $urandom;
        dut.core.RegFile.RFMem[i] = mreg[i];
      end
      for (int k = 0; k < 10; k++) begin
        kind = $urandom_range(0, 2);
        rd   = 5'($urandom_range(0, 7));
        rs1  = 5'($urandom_range(0, 7));
        rs2  = 5'($urandom_range(0, 7));
        f3   = 3'($urandom_range(0, 7));
        alt  = ((f3 == 3'd0 && kind == 0) || f3 == 3'd5) ? 1'($urandom_range(0, 1)) : 1'b0;
        a    = mreg[rs1];
        if (kind == 0) begin
          b     = mreg[rs2];
          instr = enc_r(alt ? 7'b0100000 : 7'b0, rs2, rs1, f3, rd);
          res   = alu_ref(f3, alt, a, b);
        end else if (kind == 1) begin
          imm = 12'($urandom);
          if (f3 == 3'd1 || f3 == 3'd5) imm = {1'b0, alt, 5'd0, imm[4:0]};
          b     = {{20{imm[11]}}, imm};
          instr = enc_i(imm, rs1, f3, rd, 7'b0010011);
          res   = alu_ref(f3, alt, a, b);
        end else begin
          uimm  = 20'($urandom);
          instr = {uimm, rd, 7'b0110111};
          res   = {uimm, 12'd0};
        end
        if (rd != 5'd0) mreg[rd] = res;
        dut.memory.M[k] = instr;
      end
      release_reset();
      wait_fetch_at(32'd40, 300, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL rand%0d_timeout: pc %h want 28", r, dut.core.fetch.pc_cur); end
      for (int i = 0; i < 8; i++) begin
        n_cmp++; if (dut.core.RegFile.RFMem[i] !== mreg[i]) begin n_bad++; $display("FAIL rand%0d_x%0d: got %h want %h", r, i, dut.core.RegFile.RFMem[i], mreg[i]); end
      end
    end
  endtask

  task automatic test_control_flow();
    logic [31:0] exp_pc [0:4];
    exp_pc = '{32'd8, 32'd4, 32'd16, 32'd20, 32'd24};
    hold_reset();
    dut.memory.M[0] = enc_b(13'd8, 5'd0, 5'd0, 3'b000);
    dut.memory.M[2] = enc_j(21'h1FFFFC, 5'd1);
    dut.memory.M[1] = enc_b(13'd12, 5'd0, 5'd1, 3'b001);
    dut.memory.M[4] = enc_b(13'd8, 5'd0, 5'd0, 3'b001);
    dut.memory.M[5] = enc_b(13'd8, 5'd0, 5'd1, 3'b000);
    release_reset();
    for (int s = 0; s < 5; s++) begin
      for (int c = 0; c < 4; c++) tick();
      n_cmp++; if (dut.core.control_fsm.current_state !== 6'd0 || dut.core.fetch.pc_cur !== exp_pc[s]) begin n_bad++; $display("FAIL flow%0d: state %0d pc %0d want 0/%0d", s, dut.core.control_fsm.current_state, dut.core.fetch.pc_cur, exp_pc[s]); end
      if (s == 1) begin
        n_cmp++; if (dut.core.RegFile.RFMem[1] !== 32'd12) begin n_bad++; $display("FAIL jal_link: got %0d want 12", dut.core.RegFile.RFMem[1]); end
      end
    end
  endtask

  task automatic test_reset_midwrite();
    hold_reset();
    dut.core.RegFile.RFMem[6] = 32'd44;
    dut.core.RegFile.RFMem[5] = 32'h12345678;
    dut.memory.M[11] = 32'hDEADBEEF;
    dut.memory.M[0]  = enc_s(12'd0, 5'd5, 5'd6);
    release_reset();
    for (int c = 0; c < 4; c++) tick();
    n_cmp++; if (dut.core.control_fsm.current_state !== 6'd6) begin n_bad++; $display("FAIL midrst_pre: state %0d want 6", dut.core.control_fsm.current_state); end
    #2 reset = 1'b1;
    #1;
    n_cmp++; if (dut.core.control_fsm.current_state !== 6'd0 || dut.core.fetch.pc_cur !== 32'd0) begin n_bad++; $display("FAIL midrst_async: state %0d pc %h want 0/0", dut.core.control_fsm.current_state, dut.core.fetch.pc_cur); end
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++; if (dut.memory.M[11] !== 32'hDEADBEEF) begin n_bad++; $display("FAIL midrst_mem: got %h want deadbeef", dut.memory.M[11]); end
    n_cmp++; if (dut.core.RegFile.RFMem[5] !== 32'h12345678 || dut.core.RegFile.RFMem[6] !== 32'd44) begin n_bad++; $display("FAIL midrst_rf: x5 %h x6 %h want 12345678/2c", dut.core.RegFile.RFMem[5], dut.core.RegFile.RFMem[6]); end
    n_cmp++; if (dut.core.opcode !== 7'd0) begin n_bad++; $display("FAIL midrst_ir: got %b want 0", dut.core.opcode); end
  endtask

  initial begin
    test_reset();
    test_sw_sequence();
    test_lw();
    test_alu_directed();
    test_alu_random();
    test_control_flow();
    test_reset_midwrite();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
